// File: rtl/mem_map_pkg.sv
// Shared address-map definitions for the data-side router: region codes,
// register offsets inside the 16-byte IO window and STATUS bit positions.
package mem_map_pkg;

  typedef enum logic [1:0] {
    REG_DMEM,
    REG_FB,
    REG_IO,
    REG_NONE
  } region_t;

  localparam logic [3:0] OFF_MODE   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CLR    = 4'h8;
  localparam logic [3:0] OFF_COUNT  = 4'hC;

  localparam int ST_PEND   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_ERR    = 3;
  localparam int ST_CNT_LO = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered storage; head visible combinationally (zero when empty).
// Push is ignored while full and pop while empty; no full-cycle bypass.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count  = r_wr_ptr - r_rd_ptr;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign pop_dat = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/mem_io_router.sv
// Data-side router: core accesses go to dmem (passthrough), framebuffer (posted FIFO)
// or control regs; stalls the core only on a framebuffer store into a full FIFO.
module mem_io_router
  import mem_map_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] FB_BASE    = 32'h1000,
  parameter int          FB_WORDS   = 1024,
  parameter logic [31:0] IO_BASE    = 32'h2000,
  parameter int          WBUF_DEPTH = 4,
  parameter int          MODE_W     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  input  logic                        cpu_we,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_stall,
  output logic [31:0]                 dmem_addr,
  output logic                        dmem_we,
  output logic [DATA_W-1:0]           dmem_wdata,
  input  logic [DATA_W-1:0]           dmem_rdata,
  output logic [$clog2(FB_WORDS)-1:0] fb_addr,
  output logic [DATA_W-1:0]           fb_wdata,
  output logic                        fb_we,
  input  logic                        fb_ready,
  input  logic                        btn_async,
  output logic [MODE_W-1:0]           vga_mode
);

  localparam int          FBA_W  = $clog2(FB_WORDS);
  localparam int          CNT_W  = $clog2(WBUF_DEPTH) + 1;
  localparam logic [31:0] FB_END = FB_BASE + 32'(4 * FB_WORDS);
  localparam logic [31:0] IO_END = IO_BASE + 32'd16;

  region_t               w_region;
  logic [3:0]            w_io_off;
  logic [FBA_W-1:0]      w_fb_idx;
  logic                  w_fb_wr;
  logic                  w_mode_wr;
  logic                  w_clr_wr;
  logic                  w_btn_rise;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [DATA_W-1:0]     w_status;

  logic                  r_btn_s1;
  logic                  r_btn_s2;
  logic                  r_btn_s3;
  logic                  r_pend;
  logic                  r_err;
  logic [7:0]            r_press_cnt;
  logic [MODE_W-1:0]     r_mode;

  always_comb begin
    w_region = REG_NONE;
    if (cpu_addr < FB_BASE)                           w_region = REG_DMEM;
    else if (cpu_addr < FB_END)                       w_region = REG_FB;
    else if (cpu_addr >= IO_BASE && cpu_addr < IO_END) w_region = REG_IO;
  end

  assign w_io_off  = 4'(cpu_addr - IO_BASE);
  assign w_fb_idx  = FBA_W'((cpu_addr - FB_BASE) >> 2);
  assign w_fb_wr   = cpu_we && (w_region == REG_FB);
  assign w_mode_wr = cpu_we && (w_region == REG_IO) && (w_io_off == OFF_MODE);
  assign w_clr_wr  = cpu_we && (w_region == REG_IO) && (w_io_off == OFF_CLR);

  assign dmem_addr  = cpu_addr;
  assign dmem_wdata = cpu_wdata;
  assign dmem_we    = cpu_we && (w_region == REG_DMEM);
  assign cpu_stall  = w_fb_wr && w_full;
  assign fb_we      = !w_empty;
  assign vga_mode   = r_mode;

  sync_fifo #(
    .WIDTH (FBA_W + DATA_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .push     (w_fb_wr),
    .push_dat ({w_fb_idx, cpu_wdata}),
    .pop      (fb_we && fb_ready),
    .pop_dat  ({fb_addr, fb_wdata}),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

  assign w_btn_rise = r_btn_s2 && !r_btn_s3;

  // Sticky flags: a set and a clear landing in the same cycle resolve to set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
      r_btn_s3    <= 1'b0;
      r_pend      <= 1'b0;
      r_err       <= 1'b0;
      r_press_cnt <= '0;
      r_mode      <= '0;
    end else begin
      r_btn_s1 <= btn_async;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
      if (w_btn_rise) begin
        r_pend      <= 1'b1;
        r_press_cnt <= r_press_cnt + 8'd1;
      end else if (w_clr_wr && cpu_wdata[ST_PEND]) begin
        r_pend <= 1'b0;
      end
      if (w_region == REG_NONE)                   r_err <= 1'b1;
      else if (w_clr_wr && cpu_wdata[ST_ERR])     r_err <= 1'b0;
      if (w_mode_wr) r_mode <= cpu_wdata[MODE_W-1:0];
    end
  end

  always_comb begin
    w_status                    = '0;
    w_status[ST_PEND]           = r_pend;
    w_status[ST_EMPTY]          = w_empty;
    w_status[ST_FULL]           = w_full;
    w_status[ST_ERR]            = r_err;
    w_status[ST_CNT_LO +: 8]    = r_press_cnt;
  end

  always_comb begin
    cpu_rdata = '0;
    case (w_region)
      REG_DMEM: cpu_rdata = dmem_rdata;
      REG_IO: begin
        case (w_io_off)
          OFF_MODE:   cpu_rdata = DATA_W'(r_mode);
          OFF_STATUS: cpu_rdata = w_status;
          OFF_COUNT:  cpu_rdata = DATA_W'(w_count);
          default:    cpu_rdata = '0;
        endcase
      end
      default:  cpu_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_io_router.sv
// Scoreboard bench for mem_io_router: directed stimulus queues expected loads and
// framebuffer writes; a negedge monitor pops and compares as the DUT presents them.
module tb_mem_io_router;

  localparam logic [31:0] FB = 32'h1000;
  localparam logic [31:0] IO = 32'h2000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [9:0]  fb_addr;
  logic [31:0] fb_wdata;
  logic        fb_we;
  logic        fb_ready;
  logic        btn_async;
  logic [3:0]  vga_mode;

  logic        tb_rd_vld = 1'b0;
  logic [41:0] fb_q[$];
  logic [31:0] rd_q[$];
  string       rd_nm_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] dmem_arr [64];

  mem_io_router #(
    .DATA_W(32), .FB_BASE(32'h1000), .FB_WORDS(1024),
    .IO_BASE(32'h2000), .WBUF_DEPTH(4), .MODE_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_ready(fb_ready),
    .btn_async(btn_async), .vga_mode(vga_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dmem_we) dmem_arr[dmem_addr[7:2]] <= dmem_wdata;
  assign dmem_rdata = dmem_arr[dmem_addr[7:2]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [41:0] e;
    if (reset && fb_we && fb_ready) begin
      if (fb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL fb_unexpected actual=%0h expected=none", {fb_addr, fb_wdata});
      end else begin
        e = fb_q.pop_front();
        chk("fb_write", {22'd0, fb_addr, fb_wdata}, {22'd0, e});
      end
    end
    if (tb_rd_vld && rd_q.size() != 0)
      chk(rd_nm_q.pop_front(), {32'd0, cpu_rdata}, {32'd0, rd_q.pop_front()});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_we = 1'b0;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_we = 1'b1;
    cyc();
    idle();
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    cpu_addr = a;
    cpu_we = 1'b0;
    rd_q.push_back(exp);
    rd_nm_q.push_back(nm);
    tb_rd_vld = 1'b1;
    cyc();
    tb_rd_vld = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) dmem_arr[i] = 32'h0;
    reset = 1'b0;
    fb_ready = 1'b0;
    btn_async = 1'b0;
    idle();
    #12;
    chk("rst_fb_we", fb_we, 0);
    chk("rst_vga_mode", vga_mode, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_stall", cpu_stall, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();

    // dmem passthrough
    cpu_addr = 32'h10; cpu_wdata = 32'hA5; cpu_we = 1'b1;
    #1;
    chk("dmem_we", dmem_we, 1);
    chk("dmem_addr", dmem_addr, 32'h10);
    chk("dmem_stall", cpu_stall, 0);
    cyc();
    idle();
    rd("dmem_load", 32'h10, 32'hA5);

    // posted writes filling the FIFO, then drain
    for (int i = 0; i < 4; i++) begin
      cpu_addr = FB + 32'(4 * i); cpu_wdata = 32'h100 + 32'(i); cpu_we = 1'b1;
      #1;
      chk("fb_store_nostall", cpu_stall, 0);
      fb_q.push_back({10'(i), 32'h100 + 32'(i)});
      cyc();
    end
    idle();
    rd("wbuf_count_full", IO + 32'hC, 32'd4);
    cpu_addr = FB + 32'd16; cpu_wdata = 32'h104; cpu_we = 1'b1;
    #1;
    chk("fb_store5_stall", cpu_stall, 1);
    cyc();
    chk("fb_stall_held", cpu_stall, 1);
    fb_ready = 1'b1;
    #1;
    chk("fb_stall_nopop_yet", cpu_stall, 1);
    cyc();
    chk("fb_stall_drop", cpu_stall, 0);
    fb_q.push_back({10'd4, 32'h104});
    cyc();
    idle();
    for (int i = 0; i < 20 && fb_q.size() != 0; i++) cyc();
    chk("fb_drained", fb_q.size(), 0);
    chk("fb_we_idle", fb_we, 0);

    // button synchroniser, PEND/PRESS_CNT and set-wins
    for (int p = 0; p < 3; p++) begin
      btn_async = 1'b1;
      repeat (3) cyc();
      btn_async = 1'b0;
      repeat (3) cyc();
    end
    repeat (2) cyc();
    rd("status_3press", IO + 32'h4, 32'h0303);
    wr(IO + 32'h8, 32'h1);
    rd("status_pend_clr", IO + 32'h4, 32'h0302);
    btn_async = 1'b1;
    cyc();
    cyc();
    wr(IO + 32'h8, 32'h1);
    rd("status_set_wins", IO + 32'h4, 32'h0403);
    btn_async = 1'b0;
    repeat (4) cyc();
    wr(IO + 32'h8, 32'h1);
    rd("status_pend_clr2", IO + 32'h4, 32'h0402);

    // MODE register and write-only framebuffer window
    cpu_addr = IO; cpu_wdata = 32'h7; cpu_we = 1'b1;
    #1;
    chk("mode_before_edge", vga_mode, 0);
    cyc();
    idle();
    chk("vga_mode", vga_mode, 7);
    rd("mode_read", IO, 32'h7);
    rd("fb_load_zero", FB + 32'h8, 32'h0);

    // unmapped access sets ERR; CLR bit3 clears it
    rd("status_no_err", IO + 32'h4, 32'h0402);
    rd("unmapped_load", 32'h3000, 32'h0);
    rd("status_err", IO + 32'h4, 32'h040A);
    wr(IO + 32'h8, 32'h8);
    rd("status_err_clr", IO + 32'h4, 32'h0402);

    // reset mid-drain
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(FB + 32'h20 + 32'(4 * i), 32'h11 + 32'(i));
    wr(IO, 32'h5);
    chk("mode5", vga_mode, 5);
    rd("count3", IO + 32'hC, 32'd3);
    reset = 1'b0;
    #1;
    chk("arst_fb_we", fb_we, 0);
    chk("arst_vga_mode", vga_mode, 0);
    chk("arst_fb_addr", fb_addr, 0);
    chk("arst_fb_wdata", fb_wdata, 0);
    cpu_addr = IO + 32'hC;
    #1;
    chk("arst_count", cpu_rdata, 0);
    chk("arst_stall", cpu_stall, 0);
    cyc();
    reset = 1'b1;
    idle();
    fb_ready = 1'b1;
    repeat (3) cyc();
    chk("post_rst_fb_we", fb_we, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
